eth_speed_detect: RTL and testbench

- Parametrised RGMII link-speed detector. Runs on the GTX reference clock and classifies received-clock activity as 10M, 100M, 1000M or no clock.
- The input is a divided-down toggle from the PHY receive-clock domain. The block compares its transition count per measurement window against thresholds.
- Adds multi-window confirmation (hysteresis), link-loss detection, change pulse, enable and debug count.
- Drives the speed/mii_select configuration of the RGMII PHY interface and the MAC.

---
 rtl/eth_speed_detect.sv | 115 +++++++++++
 tb/tb_eth_speed_detect.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/eth_speed_detect.sv
// RGMII link-speed detector: counts receive-clock prescaler transitions per
// window on the GTX clock and commits a speed after repeated agreement.
module eth_speed_detect #(
  parameter int WINDOW_BITS     = 8,
  parameter int THRESH_1000     = 40,
  parameter int THRESH_100      = 6,
  parameter int THRESH_10       = 1,
  parameter int CONFIRM_WINDOWS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rx_toggle,
  output logic [1:0]           speed,
  output logic                 mii_select,
  output logic                 link_up,
  output logic                 speed_change,
  output logic [WINDOW_BITS:0] edge_count
);

  localparam int EW = WINDOW_BITS + 1;
  localparam logic [EW-1:0] T1000 = EW'(THRESH_1000);
  localparam logic [EW-1:0] T100  = EW'(THRESH_100);
  localparam logic [EW-1:0] T10   = EW'(THRESH_10);
  localparam logic [3:0]    CONF  = 4'(CONFIRM_WINDOWS);

  typedef enum logic [1:0] {
    CLS_10   = 2'b00,
    CLS_100  = 2'b01,
    CLS_1000 = 2'b10,
    CLS_NONE = 2'b11
  } cls_t;

  logic [2:0]             sync;
  logic                   edge_seen;
  logic [WINDOW_BITS-1:0] win_cnt;
  logic                   win_end;
  logic [EW-1:0]          edge_cnt;
  logic [EW-1:0]          total;
  cls_t                   cand;
  cls_t                   cls;
  logic [3:0]             conf_cnt;
  logic [3:0]             conf_nxt;
  logic                   differs;
  logic                   commit;

  always_comb begin
    edge_seen = sync[2] ^ sync[1];
    win_end   = enable & (&win_cnt);
    // the transition flagged in the window-end cycle still belongs to it
    total = edge_cnt;
    if (edge_seen && !(&edge_cnt)) total = edge_cnt + 1'b1;
    cls = CLS_NONE;
    if (total >= T1000)     cls = CLS_1000;
    else if (total >= T100) cls = CLS_100;
    else if (total >= T10)  cls = CLS_10;
    conf_nxt = 4'd1;
    if (cls == cand)
      conf_nxt = (conf_cnt >= CONF) ? CONF : conf_cnt + 4'd1;
    differs = (cls == CLS_NONE) ? link_up
                                : (!link_up || speed != cls);
    commit = win_end && (conf_nxt == CONF) && differs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], rx_toggle};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt    <= '0;
      edge_cnt   <= '0;
      conf_cnt   <= '0;
      cand       <= CLS_NONE;
      edge_count <= '0;
    end else if (!enable) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
      conf_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (win_end) begin
        edge_cnt   <= '0;
        edge_count <= total;
        cand       <= cls;
        conf_cnt   <= conf_nxt;
      end else begin
        edge_cnt <= total;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed        <= 2'b10;
      mii_select   <= 1'b0;
      link_up      <= 1'b0;
      speed_change <= 1'b0;
    end else begin
      speed_change <= commit;
      if (commit) begin
        // a lost link keeps the last speed so the MAC config stays stable
        if (cls == CLS_NONE) begin
          link_up <= 1'b0;
        end else begin
          link_up    <= 1'b1;
          speed      <= cls;
          mii_select <= (cls != CLS_1000);
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_speed_detect.sv
// Scoreboard bench: stimulus queues per-window expectations, a monitor
// compares them at each window end and flags any unexpected pulse.
`timescale 1ns/1ps
module tb_eth_speed_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       rx_toggle = 1'b0;
  logic [1:0] speed;
  logic       mii_select;
  logic       link_up;
  logic       speed_change;
  logic [8:0] edge_count;

  eth_speed_detect dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rx_toggle    (rx_toggle),
    .speed        (speed),
    .mii_select   (mii_select),
    .link_up      (link_up),
    .speed_change (speed_change),
    .edge_count   (edge_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    int         lo;
    int         hi;
    bit         lk;
    logic [1:0] sp;
    bit         pulse;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wcnt = 0;
  bit   we_flag = 1'b0;
  int   probe_req = 0;
  int   probe_done = 0;
  int   ph = 0;
  exp_t e;

  task automatic chk(string name, int act, int lo, int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // reference window timer
  always @(posedge clk) begin
    we_flag = 1'b0;
    if (rst || !enable) begin
      wcnt = 0;
    end else begin
      we_flag = (wcnt == 255);
      wcnt = (wcnt + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (we_flag || probe_req != probe_done) begin
      if (probe_req != probe_done) probe_done++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL no_expect: got window end, want none");
      end else begin
        e = q.pop_front();
        chk($sformatf("w%0d.edge", e.id), int'(edge_count), e.lo, e.hi);
        chk($sformatf("w%0d.link", e.id), int'(link_up), e.lk, e.lk);
        chk($sformatf("w%0d.speed", e.id), int'(speed), e.sp, e.sp);
        chk($sformatf("w%0d.mii", e.id), int'(mii_select),
            (e.sp != 2'b10), (e.sp != 2'b10));
        chk($sformatf("w%0d.pulse", e.id), int'(speed_change),
            e.pulse, e.pulse);
      end
    end else begin
      chk("stray_pulse", int'(speed_change), 0, 0);
    end
  end

  task automatic push(int id, int lo, int hi, bit lk,
                      logic [1:0] sp, bit pulse);
    exp_t x;
    x.id = id; x.lo = lo; x.hi = hi;
    x.lk = lk; x.sp = sp; x.pulse = pulse;
    q.push_back(x);
  endtask

  task automatic drive(int per, bit on);
    if (per > 0 && on) begin
      ph++;
      if (ph >= per) begin
        ph = 0;
        rx_toggle = ~rx_toggle;
      end
    end
  endtask

  task automatic idle(int n, int per);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive(per, 1'b1);
    end
  endtask

  // one full window; tail = trailing cycles with toggling paused
  task automatic run_win(int id, int per, int tail, int lo, int hi,
                         bit lk, logic [1:0] sp, bit pulse);
    push(id, lo, hi, lk, sp, pulse);
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      drive(per, c < 256 - tail);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    push(0, 0, 0, 1'b0, 2'b10, 1'b0);
    probe_req++;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    rst = 1'b0;
    // 1000M
    run_win(1, 4, 0, 60, 64, 1'b0, 2'b10, 1'b0);
    run_win(2, 4, 0, 64, 64, 1'b0, 2'b10, 1'b0);
    run_win(3, 4, 0, 64, 64, 1'b1, 2'b10, 1'b1);
    run_win(4, 4, 0, 64, 64, 1'b1, 2'b10, 1'b0);
    // 100M
    run_win(5, 20, 0, 11, 14, 1'b1, 2'b10, 1'b0);
    run_win(6, 20, 0, 12, 13, 1'b1, 2'b10, 1'b0);
    run_win(7, 20, 0, 12, 13, 1'b1, 2'b01, 1'b1);
    run_win(8, 20, 0, 12, 13, 1'b1, 2'b01, 1'b0);
    // 10M
    run_win(9, 200, 0, 1, 3, 1'b1, 2'b01, 1'b0);
    run_win(10, 200, 0, 1, 2, 1'b1, 2'b01, 1'b0);
    run_win(11, 200, 0, 1, 2, 1'b1, 2'b00, 1'b1);
    run_win(12, 200, 0, 1, 2, 1'b1, 2'b00, 1'b0);
    // alternating rates never confirm
    for (int i = 0; i < 3; i++) begin
      run_win(13 + 2 * i, 4, 0, 60, 66, 1'b1, 2'b00, 1'b0);
      run_win(14 + 2 * i, 20, 0, 10, 15, 1'b1, 2'b00, 1'b0);
    end
    run_win(19, 4, 0, 60, 66, 1'b1, 2'b00, 1'b0);
    run_win(20, 4, 0, 64, 64, 1'b1, 2'b00, 1'b0);
    run_win(21, 4, 8, 60, 64, 1'b1, 2'b10, 1'b1);
    // link loss and recovery
    run_win(22, 0, 0, 0, 0, 1'b1, 2'b10, 1'b0);
    run_win(23, 0, 0, 0, 0, 1'b1, 2'b10, 1'b0);
    run_win(24, 0, 0, 0, 0, 1'b0, 2'b10, 1'b1);
    run_win(25, 0, 0, 0, 0, 1'b0, 2'b10, 1'b0);
    run_win(26, 4, 0, 60, 64, 1'b0, 2'b10, 1'b0);
    run_win(27, 4, 0, 64, 64, 1'b0, 2'b10, 1'b0);
    run_win(28, 4, 0, 64, 64, 1'b1, 2'b10, 1'b1);
    // partial window, disable, then async reset mid-window
    idle(100, 4);
    enable = 1'b0;
    idle(100, 4);
    push(40, 64, 64, 1'b1, 2'b10, 1'b0);
    probe_req++;
    idle(2, 4);
    enable = 1'b1;
    idle(50, 4);
    @(posedge clk);
    #2 rst = 1'b1;
    push(41, 0, 0, 1'b0, 2'b10, 1'b0);
    probe_req++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_win(29, 4, 0, 58, 66, 1'b0, 2'b10, 1'b0);
    run_win(30, 4, 0, 64, 64, 1'b0, 2'b10, 1'b0);
    run_win(31, 4, 0, 64, 64, 1'b1, 2'b10, 1'b1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
